// File: rtl/rf_wb_arbiter_pkg.sv
// Shared types for the register-file writeback arbiter.
package rf_arb_pkg;

    typedef logic [4:0]  regbits_t;
    typedef logic [31:0] word_t;

    typedef struct packed {
        regbits_t wsel;
        word_t    wdat;
    } wb_entry_t;

    localparam regbits_t REG_ZERO = 5'd0;

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Bus bundle for the register-file writeback arbiter.
// The master modport is the arbiter, which owns the register-file write
// port. The slave modport is the surrounding pipeline, mul/div unit and
// register file.
interface rf_wb_arbiter_if #(
    parameter int DEPTH = 2
);
    import rf_arb_pkg::*;

    localparam int CW = $clog2(DEPTH + 1);

    logic          pipe_wen;
    regbits_t      pipe_wsel;
    word_t         pipe_wdat;
    logic          md_valid;
    regbits_t      md_wsel;
    word_t         md_wdat;
    logic          md_ready;
    regbits_t      rsel1;
    regbits_t      rsel2;
    logic          pend_hit1;
    logic          pend_hit2;
    logic          wb_stall;
    logic          rf_wen;
    regbits_t      rf_wsel;
    word_t         rf_wdat;
    logic [CW-1:0] q_count;

    modport master (
        input  pipe_wen, pipe_wsel, pipe_wdat,
        input  md_valid, md_wsel, md_wdat,
        input  rsel1, rsel2,
        output md_ready, pend_hit1, pend_hit2, wb_stall,
        output rf_wen, rf_wsel, rf_wdat, q_count
    );

    modport slave (
        output pipe_wen, pipe_wsel, pipe_wdat,
        output md_valid, md_wsel, md_wdat,
        output rsel1, rsel2,
        input  md_ready, pend_hit1, pend_hit2, wb_stall,
        input  rf_wen, rf_wsel, rf_wdat, q_count
    );

endinterface

// File: rtl/rf_wb_arbiter_fifo.sv
// wb_fifo: small circular queue of pending mul/div writebacks.
// The pointers are one bit wider than the index, so full and empty can be
// told apart. The destination field of every slot is exposed together with
// a per-slot valid mask. The arbiter uses them to compare decode read
// selects against queued destinations.
module wb_fifo
    import rf_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push,
    input  wb_entry_t                     push_data,
    input  logic                          pop,
    output wb_entry_t                     head,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(DEPTH+1)-1:0]    count,
    output regbits_t [DEPTH-1:0]          slot_wsel,
    output logic [DEPTH-1:0]              slot_vld
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    wb_entry_t [DEPTH-1:0] mem;
    logic [AW:0]           wr_ptr;
    logic [AW:0]           rd_ptr;
    logic [AW-1:0]         off;

    assign count = CW'(wr_ptr - rd_ptr);
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (count == CW'(DEPTH));
    assign head  = mem[rd_ptr[AW-1:0]];

    // Advance the pointers on each accepted push and pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Slot storage has no reset. The pointers alone define which slots are live.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    // A slot is live when its distance from the head is below the occupancy.
    always_comb begin
        slot_vld = '0;
        off      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off          = AW'(i) - rd_ptr[AW-1:0];
            slot_vld[i]  = ({1'b0, off} < count);
            slot_wsel[i] = mem[i].wsel;
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: owns the single register-file write port. The port is
// shared between pipeline writeback and queued mul/div results. An age
// counter on the queue head forces a one-cycle writeback stall, so queued
// results cannot starve.
// Optional build macro WB_BYPASS_EN lets a mul/div result skip an empty
// queue when the port is otherwise idle.
module rf_wb_arbiter
    import rf_arb_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input logic             CLK,
    input logic             nRST,
    rf_wb_arbiter_if.master bus
);
    localparam int             CW      = $clog2(DEPTH + 1);
    localparam int             AGW     = $clog2(STARVE_LIMIT + 1);
    localparam logic [AGW-1:0] AGE_MAX = AGW'(STARVE_LIMIT);

    wb_entry_t            head;
    wb_entry_t            push_data;
    logic                 push;
    logic                 pop;
    logic                 full;
    logic                 empty;
    logic [CW-1:0]        count;
    regbits_t [DEPTH-1:0] slot_wsel;
    logic [DEPTH-1:0]     slot_vld;
    logic [AGW-1:0]       age;
    logic                 stall;
    logic                 pipe_act;
    logic                 md_act;
    logic                 byp;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (CLK),
        .rst_n     (nRST),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .slot_wsel (slot_wsel),
        .slot_vld  (slot_vld)
    );

    assign push_data    = {bus.md_wsel, bus.md_wdat};
    assign md_act       = bus.md_valid && (bus.md_wsel != REG_ZERO);
    assign pipe_act     = bus.pipe_wen && (bus.pipe_wsel != REG_ZERO);
    assign stall        = !empty && (age == AGE_MAX);
    assign push         = md_act && !full && !byp;
    assign bus.md_ready = !full;
    assign bus.q_count  = count;
    assign bus.wb_stall = stall;

    // Write-port grant: a forced drain wins first, then the pipeline, then the
    // queue head. While reset is held the port stays quiet, whatever inputs
    // are applied.
    always_comb begin
        bus.rf_wen  = 1'b0;
        bus.rf_wsel = REG_ZERO;
        bus.rf_wdat = '0;
        pop         = 1'b0;
        byp         = 1'b0;
        if (nRST) begin
            if (stall) begin
                bus.rf_wen  = 1'b1;
                bus.rf_wsel = head.wsel;
                bus.rf_wdat = head.wdat;
                pop         = 1'b1;
            end else if (pipe_act) begin
                bus.rf_wen  = 1'b1;
                bus.rf_wsel = bus.pipe_wsel;
                bus.rf_wdat = bus.pipe_wdat;
            end else if (!empty) begin
                bus.rf_wen  = 1'b1;
                bus.rf_wsel = head.wsel;
                bus.rf_wdat = head.wdat;
                pop         = 1'b1;
`ifdef WB_BYPASS_EN
            end else if (md_act) begin
                bus.rf_wen  = 1'b1;
                bus.rf_wsel = bus.md_wsel;
                bus.rf_wdat = bus.md_wdat;
                byp         = 1'b1;
`endif
            end
        end
    end

    // Count cycles the head waits. Clear on dequeue or empty, saturate at the limit.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            age <= '0;
        end else if (pop || empty) begin
            age <= '0;
        end else if (age != AGE_MAX) begin
            age <= age + 1'b1;
        end
    end

    // Flag decode reads of registers that still have a queued write.
    // Same-register ordering is left to the hazard unit, via these flags.
    always_comb begin
        bus.pend_hit1 = 1'b0;
        bus.pend_hit2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (slot_vld[i] && (slot_wsel[i] == bus.rsel1)) bus.pend_hit1 = 1'b1;
            if (slot_vld[i] && (slot_wsel[i] == bus.rsel2)) bus.pend_hit2 = 1'b1;
        end
        if (bus.rsel1 == REG_ZERO) bus.pend_hit1 = 1'b0;
        if (bus.rsel2 == REG_ZERO) bus.pend_hit2 = 1'b0;
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Testbench for rf_wb_arbiter: directed scenarios followed by randomized
// traffic, checked against a queue-based reference model.
module tb_rf_wb_arbiter;
    import rf_arb_pkg::*;

    localparam int DEPTH = 2;
    localparam int LIM   = 4;
`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic CLK = 1'b0;
    logic nRST = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    wb_entry_t m_q[$];
    int        m_age = 0;

    rf_wb_arbiter_if #(.DEPTH(DEPTH)) bus();

    rf_wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIM)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input int unsigned pw, input int unsigned psel, input int unsigned pdat,
                         input int unsigned mv, input int unsigned msel, input int unsigned mdat,
                         input int unsigned r1, input int unsigned r2);
        bus.pipe_wen  = pw[0];
        bus.pipe_wsel = 5'(psel);
        bus.pipe_wdat = 32'(pdat);
        bus.md_valid  = mv[0];
        bus.md_wsel   = 5'(msel);
        bus.md_wdat   = 32'(mdat);
        bus.rsel1     = 5'(r1);
        bus.rsel2     = 5'(r2);
    endtask

    // Outputs while reset is asserted must be quiet, whatever inputs are applied.
    task automatic rst_check();
        check("rst_rf_wen",   32'(bus.rf_wen),    32'd0);
        check("rst_rf_wsel",  32'(bus.rf_wsel),   32'd0);
        check("rst_rf_wdat",  bus.rf_wdat,        32'd0);
        check("rst_wb_stall", 32'(bus.wb_stall),  32'd0);
        check("rst_md_ready", 32'(bus.md_ready),  32'd1);
        check("rst_q_count",  32'(bus.q_count),   32'd0);
        check("rst_pend1",    32'(bus.pend_hit1), 32'd0);
        check("rst_pend2",    32'(bus.pend_hit2), 32'd0);
    endtask

    task automatic do_reset(input int cycles);
        @(negedge CLK);
        drive(1, 3, 32'h33, 1, 5, 32'hAA, 5, 5);
        nRST = 1'b0;
        #1;
        m_q.delete();
        m_age = 0;
        rst_check();
        repeat (cycles) @(negedge CLK);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        nRST = 1'b1;
    endtask

    // One clock cycle: apply inputs, predict and compare the outputs, then
    // advance the model across the clock edge.
    task automatic step(input int unsigned pw, input int unsigned psel, input int unsigned pdat,
                        input int unsigned mv, input int unsigned msel, input int unsigned mdat,
                        input int unsigned r1, input int unsigned r2);
        logic        e_wen, e_stall, e_ready, e_h1, e_h2, deq, bypass, pipe_w, md_w;
        logic [4:0]  e_sel;
        logic [31:0] e_dat;
        int          old_n;
        @(negedge CLK);
        drive(pw, psel, pdat, mv, msel, mdat, r1, r2);
        #1;
        old_n   = m_q.size();
        pipe_w  = (pw != 0) && (psel[4:0] != 5'd0);
        md_w    = (mv != 0) && (msel[4:0] != 5'd0);
        e_ready = (old_n < DEPTH);
        e_stall = (old_n > 0) && (m_age == LIM);
        e_wen   = 1'b0;
        e_sel   = 5'd0;
        e_dat   = 32'd0;
        deq     = 1'b0;
        bypass  = 1'b0;
        if (e_stall || (!pipe_w && old_n > 0)) begin
            e_wen = 1'b1; e_sel = m_q[0].wsel; e_dat = m_q[0].wdat; deq = 1'b1;
        end else if (pipe_w) begin
            e_wen = 1'b1; e_sel = psel[4:0]; e_dat = pdat;
        end else if (BYP && md_w) begin
            e_wen = 1'b1; e_sel = msel[4:0]; e_dat = mdat; bypass = 1'b1;
        end
        e_h1 = 1'b0;
        e_h2 = 1'b0;
        foreach (m_q[i]) begin
            if (r1 != 0 && m_q[i].wsel == r1[4:0]) e_h1 = 1'b1;
            if (r2 != 0 && m_q[i].wsel == r2[4:0]) e_h2 = 1'b1;
        end
        check("rf_wen",    32'(bus.rf_wen),    32'(e_wen));
        check("rf_wsel",   32'(bus.rf_wsel),   32'(e_sel));
        check("rf_wdat",   bus.rf_wdat,        e_dat);
        check("wb_stall",  32'(bus.wb_stall),  32'(e_stall));
        check("md_ready",  32'(bus.md_ready),  32'(e_ready));
        check("q_count",   32'(bus.q_count),   32'(old_n));
        check("pend_hit1", 32'(bus.pend_hit1), 32'(e_h1));
        check("pend_hit2", 32'(bus.pend_hit2), 32'(e_h2));
        @(posedge CLK);
        if (deq) void'(m_q.pop_front());
        if (md_w && e_ready && !bypass) m_q.push_back({msel[4:0], mdat});
        if (old_n > 0 && !deq) m_age = (m_age < LIM) ? m_age + 1 : LIM;
        else                   m_age = 0;
    endtask

    initial begin
        drive(1, 3, 32'h33, 1, 5, 32'hAA, 5, 0);
        nRST = 1'b0;
        repeat (2) @(negedge CLK);
        #1;
        rst_check();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        nRST = 1'b1;

        // enqueue right after reset, then drain on an idle port
        step(0, 0, 0, 1, 5, 32'hAA, 5, 0);
        step(0, 0, 0, 0, 0, 0, 5, 0);
        step(0, 0, 0, 1, 5, 32'h11, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        // busy pipe starves queued r7 until the forced drain
        step(1, 3, 32'h33, 1, 7, 32'h77, 7, 0);
        repeat (7) step(1, 3, 32'h33, 0, 0, 0, 7, 3);
        // fill with pipe busy, probe pending flags
        step(1, 3, 32'h33, 1, 8, 32'h88, 8, 0);
        step(1, 3, 32'h33, 1, 9, 32'h99, 9, 0);
        step(1, 3, 32'h33, 1, 12, 32'hCC, 9, 0);
        step(1, 3, 32'h33, 0, 0, 0, 9, 8);
        repeat (6) step(0, 0, 0, 0, 0, 0, 8, 9);
        // register zero on both sources
        step(1, 0, 32'h55, 1, 0, 32'h66, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        // enqueue and dequeue in the same cycle at count 1
        step(1, 3, 32'h33, 1, 4, 32'h44, 4, 10);
        step(0, 0, 0, 1, 10, 32'hA0, 10, 4);
        step(1, 3, 32'h33, 0, 0, 0, 10, 4);
        repeat (6) step(1, 3, 32'h33, 0, 0, 0, 10, 0);

        for (int c = 0; c < 2000; c++) begin
            int unsigned busy;
            if (c == 1000) do_reset(2);
            busy = (c % 400 < 200) ? 6 : 2;
            step(($urandom_range(0, 7) < busy) ? 1 : 0,
                 ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 31),
                 $urandom,
                 $urandom_range(0, 1),
                 ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 15),
                 $urandom,
                 $urandom_range(0, 15),
                 $urandom_range(0, 15));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
